// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 16-bit ALU: registers operands, waits a settle time, captures the response.
// Optional counters stat_ops/stat_eq are built when ALU_OP_SEQUENCER_STATS_EN is defined.
module alu_op_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_select,
    input  logic             cmd_mode,
    input  logic             cmd_chain,
    input  logic             cmd_cin,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    output logic [3:0]       alu_select,
    output logic             alu_mode,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_compare,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_compare,
`ifdef ALU_OP_SEQUENCER_STATS_EN
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_eq,
`endif
    output logic             carry_flag
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_in_a_q, alu_in_a_d;
    logic [WIDTH-1:0] alu_in_b_q, alu_in_b_d;
    logic [3:0]       alu_select_q, alu_select_d;
    logic             alu_mode_q, alu_mode_d;
    logic             alu_carry_in_q, alu_carry_in_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_compare_q, rsp_compare_d;
    logic             carry_flag_q, carry_flag_d;
    logic             accept;
    logic             capture;
    logic             cap_carry;
`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0]      stat_ops_q, stat_ops_d;
    logic [15:0]      stat_eq_q, stat_eq_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        alu_in_a_d     = alu_in_a_q;
        alu_in_b_d     = alu_in_b_q;
        alu_select_d   = alu_select_q;
        alu_mode_d     = alu_mode_q;
        alu_carry_in_d = alu_carry_in_q;
        rsp_data_d     = rsp_data_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_compare_d  = rsp_compare_q;
        carry_flag_d   = carry_flag_q;

        accept    = (state_q == IDLE) && !flush && cmd_valid;
        capture   = (state_q == SETTLE) && (cnt_q == 4'd0) && !flush;
        cap_carry = alu_mode_q ? alu_carry_out : 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_in_a_d     = cmd_a;
                    alu_in_b_d     = cmd_b;
                    alu_select_d   = cmd_select;
                    alu_mode_d     = cmd_mode;
                    alu_carry_in_d = cmd_chain ? carry_flag_q : cmd_cin;
                    cnt_d          = CNT_LOAD;
                    state_d        = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            rsp_data_d    = alu_result;
            rsp_carry_d   = cap_carry;
            rsp_compare_d = alu_compare;
            carry_flag_d  = cap_carry;
        end

        // Flush overrides everything above; the ALU drive is deliberately left untouched.
        if (flush) begin
            state_d      = IDLE;
            cnt_d        = 4'd0;
            carry_flag_d = 1'b0;
        end
    end

`ifdef ALU_OP_SEQUENCER_STATS_EN
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_eq_d  = stat_eq_q;
        if (capture) begin
            stat_ops_d = stat_ops_q + 16'd1;
            if (alu_compare) begin
                stat_eq_d = stat_eq_q + 16'd1;
            end
        end
        if (flush) begin
            stat_ops_d = 16'd0;
            stat_eq_d  = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= 16'd0;
            stat_eq_q  <= 16'd0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_eq_q  <= stat_eq_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_eq  = stat_eq_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            alu_in_a_q     <= '0;
            alu_in_b_q     <= '0;
            alu_select_q   <= 4'd0;
            alu_mode_q     <= 1'b0;
            alu_carry_in_q <= 1'b0;
            rsp_data_q     <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_compare_q  <= 1'b0;
            carry_flag_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            alu_in_a_q     <= alu_in_a_d;
            alu_in_b_q     <= alu_in_b_d;
            alu_select_q   <= alu_select_d;
            alu_mode_q     <= alu_mode_d;
            alu_carry_in_q <= alu_carry_in_d;
            rsp_data_q     <= rsp_data_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_compare_q  <= rsp_compare_d;
            carry_flag_q   <= carry_flag_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE) && !flush;
    assign rsp_valid    = (state_q == RESP);
    assign alu_in_a     = alu_in_a_q;
    assign alu_in_b     = alu_in_b_q;
    assign alu_select   = alu_select_q;
    assign alu_mode     = alu_mode_q;
    assign alu_carry_in = alu_carry_in_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_compare  = rsp_compare_q;
    assign carry_flag   = carry_flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, corner sequences and a randomized scoreboard run.
module tb_alu_op_sequencer;
    localparam int W  = 16;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_select = 4'd0;
    logic         cmd_mode = 1'b0;
    logic         cmd_chain = 1'b0;
    logic         cmd_cin = 1'b0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [W-1:0] alu_in_a, alu_in_b;
    logic [3:0]   alu_select;
    logic         alu_mode, alu_carry_in;
    logic [W-1:0] alu_result;
    logic         alu_carry_out, alu_compare;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_carry, rsp_compare, carry_flag;
`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0]  stat_ops, stat_eq;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_select(cmd_select), .cmd_mode(cmd_mode), .cmd_chain(cmd_chain),
        .cmd_cin(cmd_cin), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_compare(rsp_compare),
`ifdef ALU_OP_SEQUENCER_STATS_EN
        .stat_ops(stat_ops), .stat_eq(stat_eq),
`endif
        .carry_flag(carry_flag)
    );

    // Behavioural ALU: {carry_out, compare, result}. Mode 1 select 1001 is A+B+cin, 0110 is A-B-1+cin.
    function automatic logic [17:0] alu_fn(input logic [3:0] sel, input logic mode, input logic cin,
                                           input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        co;
        s  = '0;
        r  = '0;
        co = 1'b0;
        if (mode) begin
            if (sel == 4'b0110) s = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
            else                s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r  = s[15:0];
            co = s[16];
        end else begin
            case (sel)
                4'b1011: r = a & b;
                4'b1110: r = a | b;
                4'b0110: r = a ^ b;
                default: r = ~a;
            endcase
        end
        return {co, (a == b), r};
    endfunction

    assign {alu_carry_out, alu_compare, alu_result} = alu_fn(alu_select, alu_mode, alu_carry_in, alu_in_a, alu_in_b);

    typedef struct {
        logic [3:0]  sel;
        logic        mode;
        logic        chain;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic        exp_cin;
        logic [15:0] exp_data;
        logic        exp_carry;
        logic        exp_cmp;
    } vec_t;

    vec_t vecs[8];
    logic [3:0] sel_tab[4] = '{4'b1001, 4'b1011, 4'b0110, 4'b1110};
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n;
        cmd_select = v.sel;
        cmd_mode   = v.mode;
        cmd_chain  = v.chain;
        cmd_cin    = v.cin;
        cmd_a      = v.a;
        cmd_b      = v.b;
        cmd_valid  = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check({tag, "_in_a"}, 32'(alu_in_a), 32'(v.a));
        check({tag, "_cin"}, 32'(alu_carry_in), 32'(v.exp_cin));
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(ST));
        check({tag, "_data"}, 32'(rsp_data), 32'(v.exp_data));
        check({tag, "_carry"}, 32'(rsp_carry), 32'(v.exp_carry));
        check({tag, "_cmp"}, 32'(rsp_compare), 32'(v.exp_cmp));
        check({tag, "_flag"}, 32'(carry_flag), 32'(v.exp_carry));
        step();
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
        $display("[TB] op %s a=%h b=%h -> data=%h carry=%0d cmp=%0d", tag, v.a, v.b, rsp_data, rsp_carry, rsp_compare);
    endtask

    initial begin
        int n;
        int since;
        int done;
        logic fire_c, fire_r, was_v, flag_m, cin_eff, ok;
        logic [17:0] f, e;

        vecs[0] = '{4'b1001, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{4'b1001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{4'b1001, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
        vecs[3] = '{4'b1001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{4'b1011, 1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1'b0};
        vecs[5] = '{4'b1011, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b1};
        vecs[6] = '{4'b1001, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[7] = '{4'b1001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_in_a", 32'(alu_in_a), 32'd0);
        check("rst_alu_select", 32'(alu_select), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_carry_flag", 32'(carry_flag), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure with a second command waiting
        cmd_select = 4'b1001; cmd_mode = 1'b1; cmd_chain = 1'b0; cmd_cin = 1'b0;
        cmd_a = 16'h1111; cmd_b = 16'h2222;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        check("bp_ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_select = 4'b1011; cmd_mode = 1'b0; cmd_a = 16'hAAAA; cmd_b = 16'h5555;
        n = 0;
        while (!rsp_valid && n < 20) begin
            check("bp_ready_settle", 32'(cmd_ready), 32'd0);
            step();
            n++;
        end
        check("bp_latency", 32'(n), 32'(ST));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'h3333);
            check("bp_hold_ready", 32'(cmd_ready), 32'd0);
            check("bp_hold_drive", 32'(alu_in_a), 32'h1111);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        check("bp_next_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("bp_next_accept", 32'(alu_in_a), 32'hAAAA);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_next_data", 32'(rsp_data), 32'h0000);
        check("bp_next_flag", 32'(carry_flag), 32'd0);
        step();
        $display("[TB] back-pressure sequence done");

        // Flush early in SETTLE with a command presented
        run_op(vecs[1], "flush_pre");
        cmd_select = 4'b1001; cmd_mode = 1'b1; cmd_a = 16'h0101; cmd_b = 16'h0202;
        cmd_valid = 1'b1;
        step();
        cmd_a = 16'h0F0F;
        flush = 1'b1;
        #1;
        check("flush_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        flush = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flush_carry_flag", 32'(carry_flag), 32'd0);
        check("flush_idle", 32'(cmd_ready), 32'd1);
        check("flush_drive_kept", 32'(alu_in_a), 32'h0101);
        ok = 1'b1;
        for (int i = 0; i < ST + 2; i++) begin
            step();
            if (rsp_valid) ok = 1'b0;
        end
        check("flush_no_rsp", 32'(ok), 32'd1);
        $display("[TB] flush in settle done");

        // Flush on the capture edge
        run_op(vecs[1], "flush_cap_pre");
        cmd_a = 16'hFFFF; cmd_b = 16'h0001; cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (ST - 1) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flushcap_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flushcap_flag", 32'(carry_flag), 32'd0);
        check("flushcap_idle", 32'(cmd_ready), 32'd1);
        step();
        check("flushcap_no_rsp", 32'(rsp_valid), 32'd0);
        $display("[TB] flush on capture done");

`ifdef ALU_OP_SEQUENCER_STATS_EN
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_op(vecs[0], "stat0");
        run_op(vecs[5], "stat1");
        run_op(vecs[1], "stat2");
        check("stat_ops", 32'(stat_ops), 32'd3);
        check("stat_eq", 32'(stat_eq), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stat_ops_flush", 32'(stat_ops), 32'd0);
        check("stat_eq_flush", 32'(stat_eq), 32'd0);
        $display("[TB] stats sequence done");
`endif

        // Randomized run against a scoreboard
        flush = 1'b1;
        step();
        flush = 1'b0;
        flag_m = 1'b0;
        exp_q.delete();
        since = 0;
        done = 0;
        for (int cyc = 0; cyc < 4000 && done < 200; cyc++) begin
            if (!cmd_valid || $urandom_range(0, 7) == 0) begin
                cmd_valid  = ($urandom_range(0, 2) != 0);
                cmd_select = sel_tab[$urandom_range(0, 3)];
                cmd_mode   = 1'($urandom_range(0, 1));
                cmd_chain  = 1'($urandom_range(0, 1));
                cmd_cin    = 1'($urandom_range(0, 1));
                cmd_a      = 16'($urandom);
                cmd_b      = ($urandom_range(0, 7) == 0) ? cmd_a : 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            fire_c = cmd_valid && cmd_ready;
            fire_r = rsp_valid && rsp_ready;
            was_v  = rsp_valid;
            if (fire_r) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_data", 32'(rsp_data), 32'(e[15:0]));
                    check("rand_cmp", 32'(rsp_compare), 32'(e[16]));
                    check("rand_carry", 32'(rsp_carry), 32'(e[17]));
                    check("rand_flag", 32'(carry_flag), 32'(e[17]));
                    $display("[TB] rand rsp %0d data=%h carry=%0d cmp=%0d", done, rsp_data, rsp_carry, rsp_compare);
                    done++;
                end
            end
            if (fire_c) begin
                cin_eff = cmd_chain ? flag_m : cmd_cin;
                f = alu_fn(cmd_select, cmd_mode, cin_eff, cmd_a, cmd_b);
                flag_m = cmd_mode ? f[17] : 1'b0;
                exp_q.push_back({flag_m, f[16], f[15:0]});
            end
            step();
            if (fire_c) since = 0;
            else        since++;
            if (rsp_valid && !was_v) check("rand_latency", 32'(since), 32'(ST));
        end
        check("rand_progress", 32'(done >= 50), 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (ST + 3) step();

        // Asynchronous reset while a response is pending
        cmd_select = 4'b1001; cmd_mode = 1'b1; cmd_chain = 1'b0; cmd_cin = 1'b0;
        cmd_a = 16'hFFFF; cmd_b = 16'h0001;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("arst_pre_valid", 32'(rsp_valid), 32'd1);
        check("arst_pre_flag", 32'(carry_flag), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_carry_flag", 32'(carry_flag), 32'd0);
        check("arst_alu_in_a", 32'(alu_in_a), 32'd0);
        check("arst_alu_in_b", 32'(alu_in_b), 32'd0);
        check("arst_alu_mode", 32'(alu_mode), 32'd0);
        check("arst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("arst_after_valid", 32'(rsp_valid), 32'd0);
        $display("[TB] async reset sequence done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side controller for the team's 16-bit combinational ALU. Accepts operation packets over a valid/ready handshake and drives the ALU's operand and control inputs from registers.
- Holds the drive for a programmable settle time, then captures result, carry and compare into a response register presented over valid/ready.
- Keeps a carry flag so multi-word arithmetic can be chained one word per command.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- SETTLE_CYCLES, 1, clock cycles the ALU drive is held before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort: drops the in-flight op and pending response, clears the carry flag.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_select  input  4  ALU function select.
- cmd_mode  input  1  0 = logic, 1 = arithmetic.
- cmd_chain  input  1  1 = use the stored carry flag as carry_in.
- cmd_cin  input  1  explicit carry_in, used when cmd_chain = 0.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- alu_in_a  output  WIDTH  registered drive to ALU in_a.
- alu_in_b  output  WIDTH  registered drive to ALU in_b.
- alu_select  output  4  registered drive to ALU select.
- alu_mode  output  1  registered drive to ALU mode.
- alu_carry_in  output  1  registered drive to ALU carry_in.
- alu_result  input  WIDTH  ALU alu_out.
- alu_carry_out  input  1  ALU carry_out.
- alu_compare  input  1  ALU compare.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  captured result.
- rsp_carry  output  1  captured carry.
- rsp_compare  output  1  captured compare.
- carry_flag  output  1  current stored carry.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous active-low.
- Reset values: state IDLE; cmd_ready 1; rsp_valid 0; all alu_* outputs 0; rsp_data 0; rsp_carry 0; rsp_compare 0; carry_flag 0; settle counter 0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready = 1 when flush = 0.
  - On cmd_valid && cmd_ready, register alu_in_a = cmd_a, alu_in_b = cmd_b, alu_select, alu_mode.
  - Register alu_carry_in = cmd_chain ? carry_flag : cmd_cin.
  - Load counter = SETTLE_CYCLES - 1 and go to SETTLE.
- SETTLE:
  - cmd_ready = 0.
  - If counter = 0, capture on this edge: rsp_data = alu_result, rsp_carry = alu_mode ? alu_carry_out : 0, rsp_compare = alu_compare.
  - On capture, carry_flag = rsp_carry. A logic-mode op clears the flag.
  - On capture, set rsp_valid = 1 and go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid = 1, cmd_ready = 0.
  - rsp_data, rsp_carry and rsp_compare are stable until rsp_ready.
  - On rsp_valid && rsp_ready, drop rsp_valid and go to IDLE. The next command can be accepted the following cycle.
- Latency: the capture edge is SETTLE_CYCLES edges after the accept edge. Sustained throughput is one op per SETTLE_CYCLES + 2 cycles.
- Drive stability: alu_* outputs change only on an accept edge and hold their value through SETTLE and RESP. They are not cleared on return to IDLE.
- Handshake rules:
  - cmd_valid may drop without acceptance; no state change results.
  - rsp_valid, once high, stays high until accepted or flushed.
- Flush:
  - From any state: next state IDLE, rsp_valid 0, carry_flag 0.
  - alu_* outputs keep their value; counter resets to 0.
  - flush takes priority over a simultaneous command accept: cmd_ready is low while flush = 1.
  - flush takes priority over a simultaneous capture and over a response handshake.
- Chaining with a cleared flag: cmd_chain = 1 with carry_flag = 0 drives alu_carry_in = 0.
- Reset mid-operation: immediately returns every register to its reset value. No response is produced.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_STATS_EN.
- When defined:
  - Adds outputs stat_ops (16 bits) and stat_eq (16 bits).
  - stat_ops increments on every capture edge.
  - stat_eq increments on captures with alu_compare = 1.
  - Both counters wrap modulo 2^16 and are cleared by rst_n and by flush.
- When not defined: these ports and counters do not exist; the rest of the behaviour is unchanged.

Test Plan:
- The bench uses a behavioural ALU model in which select 1001 with mode 1 computes A+B+carry_in and reports carry_out.
- Arithmetic op: SETTLE_CYCLES=1, cmd select=1001 mode=1 cin=0 A=0x0005 B=0x0003 -> rsp_valid one edge after accept, rsp_data=0x0008, rsp_carry=0, rsp_compare=0.
- Chained 32-bit add:
  - Low word: A=0xFFFF, B=0x0001, cmd_chain=0 -> rsp_data=0x0000, carry_flag=1.
  - High word: A=0x0001, B=0x0002, cmd_chain=1 -> alu_carry_in=1, rsp_data=0x0004.
- Logic op clears carry: after carry_flag=1, issue mode=0 select=1011 A=0x00F0 B=0x0FF0 -> rsp_data=0x00F0, rsp_carry=0, carry_flag=0. With A=B=0x1234 -> rsp_compare=1.
- Back-pressure: SETTLE_CYCLES=3, hold rsp_ready=0 for 5 cycles -> capture 3 edges after accept, rsp_* stable, cmd_ready=0 throughout, next command accepted the cycle after rsp_ready=1.
- Flush and reset:
  - Assert flush in SETTLE together with cmd_valid -> no response, cmd not accepted, carry_flag=0, IDLE next cycle.
  - Drop rst_n in RESP -> rsp_valid=0 and all outputs at reset values asynchronously.
- Stats (ALU_OP_SEQUENCER_STATS_EN defined): 3 ops, one with equal operands -> stat_ops=3, stat_eq=1; after flush both counters read 0.
